qpu_ifu2exu_ibuf: RTL and testbench
===================================

// Module: qpu_ifu2exu_ibuf
// PURPOSE
//  Instruction buffer between the IFU IR-stage output and the EXU decode/issue input.
//  Decouples IFU fetch from EXU stalls by holding up to DEPTH fetched instructions.
//  Each entry holds the instruction together with its PC, PC-valid, rs1/rs2 indices and predict-taken bit.
//  Drops all buffered entries on a pipeline flush so no wrong-path instruction reaches the EXU.
// PARAMETERS
//  INSTR_W     32  instruction width (QPU_INSTR_SIZE)
//  PC_W        32  PC width (QPU_PC_SIZE)
//  RFIDX_W     5   register-file index width (QPU_RFIDX_REAL_WIDTH)
//  DEPTH_LOG2  1   log2 of entry count; DEPTH = 2**DEPTH_LOG2 (range 1..4)
// PORTS
//  clk            in   1             core clock
//  rst_n          in   1             async active-low reset
//  i_valid        in   1             IFU has an instruction
//  i_ready        out  1             buffer accepts this cycle
//  i_ir           in   INSTR_W       instruction
//  i_pc           in   PC_W          instruction PC
//  i_pc_vld       in   1             PC valid flag
//  i_rs1idx       in   RFIDX_W       rs1 index
//  i_rs2idx       in   RFIDX_W       rs2 index
//  i_prdt_taken   in   1             branch predicted taken
//  o_valid        out  1             head entry valid to EXU
//  o_ready        in   1             EXU consumes head
//  o_ir/o_pc/o_pc_vld/o_rs1idx/o_rs2idx/o_prdt_taken  out  as inputs  head-entry fields
//  flush          in   1             pipeline flush (from pipe_flush_req & pipe_flush_ack)
//  o_count        out  DEPTH_LOG2+1  occupied entries
//  o_full         out  1             count == DEPTH
//  o_empty        out  1             count == 0
// BEHAVIOUR
//  - Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
//  - Reset values: rd_ptr=0, wr_ptr=0, count=0, all entry storage=0.
//    Resulting outputs: o_valid=0, i_ready=1, o_empty=1, o_full=0, o_count=0, all o_* payload=0.
//  - Storage: circular buffer of DEPTH entries.
//    Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH; count is a separate DEPTH_LOG2+1-bit register.
//  - Push when i_valid & i_ready.
//    i_ready = !o_full & !flush (no dependence on o_ready; no full-bypass).
//  - Pop when o_valid & o_ready.
//    o_valid = !o_empty & !flush.
//    Payload outputs drive entry[rd_ptr] directly; they are stable while o_valid=1 and o_ready=0.
//  - Latency: an instruction pushed in cycle N appears on o_valid at N+1 at the earliest. There is no same-cycle bypass.
//  - Count update:
//    - push only: +1
//    - pop only: -1
//    - push and pop in the same cycle: unchanged (legal whenever 0 < count < DEPTH).
//    - Entries are popped in strict push order.
//  - Flush: in a cycle with flush=1, no push and no pop occur.
//    At the next edge rd_ptr=wr_ptr=0 and count=0. Entry data is not cleared.
//  - Boundary conditions:
//    - Full: i_ready=0. An i_valid held by the IFU waits and is not lost.
//    - Empty: o_valid=0 and payload outputs show stale data; the EXU ignores them.
//    - Pointer wrap: wr_ptr DEPTH-1 -> 0 on push; rd_ptr likewise on pop.
//  - Reset mid-operation: all entries are discarded immediately and asynchronously; o_valid falls with rst_n.
//  - Assertions (simulation only): no push when full, no pop when empty, count <= DEPTH.
// TESTING
//  1. Reset, then push ir=0x11 pc=0x100 -> o_valid=1 next cycle with o_ir=0x11, o_pc=0x100, o_count=1.
//  2. DEPTH=2, o_ready=0, push A,B,C -> i_ready=0 after B. C is held.
//     Raise o_ready -> order A,B,C, C accepted the cycle after A pops.
//  3. count=1, simultaneous push and pop for 8 cycles -> o_count stays 1 and all 8 instructions emerge in order.
//  4. count=2 with i_valid=1, assert flush 1 cycle -> o_valid=0 and i_ready=0 that cycle.
//     Next cycle o_count=0 and nothing from before the flush appears.
//  5. Random valid/ready, 1000 instructions with pc incrementing by 4 -> output pc sequence has no gaps, no duplicates, no reorder.
//  6. Drop rst_n while count=2 -> o_valid=0 and o_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/qpu_ifu2exu_ibuf.sv
// Instruction buffer between the IFU IR stage and EXU decode/issue: a DEPTH-entry
// circular FIFO of instruction, PC and operand-index records, emptied on pipeline flush.
module qpu_ifu2exu_ibuf #(
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned RFIDX_W    = 5,
  parameter int unsigned DEPTH_LOG2 = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [INSTR_W-1:0]    i_ir,
  input  logic [PC_W-1:0]       i_pc,
  input  logic                  i_pc_vld,
  input  logic [RFIDX_W-1:0]    i_rs1idx,
  input  logic [RFIDX_W-1:0]    i_rs2idx,
  input  logic                  i_prdt_taken,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [INSTR_W-1:0]    o_ir,
  output logic [PC_W-1:0]       o_pc,
  output logic                  o_pc_vld,
  output logic [RFIDX_W-1:0]    o_rs1idx,
  output logic [RFIDX_W-1:0]    o_rs2idx,
  output logic                  o_prdt_taken,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    pc;
    logic               pc_vld;
    logic [RFIDX_W-1:0] rs1idx;
    logic [RFIDX_W-1:0] rs2idx;
    logic               prdt_taken;
  } entry_t;

  entry_t                entry_q [DEPTH];
  entry_t                entry_d [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop;
  entry_t                head;

  // Flush blocks both handshakes so a wrong-path instruction is neither taken nor issued.
  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);
  assign i_ready = !o_full && !flush;
  assign o_valid = !o_empty && !flush;
  assign push    = i_valid && i_ready;
  assign pop     = o_valid && o_ready;
  assign o_count = count_q;

  assign head         = entry_q[rd_ptr_q];
  assign o_ir         = head.ir;
  assign o_pc         = head.pc;
  assign o_pc_vld     = head.pc_vld;
  assign o_rs1idx     = head.rs1idx;
  assign o_rs2idx     = head.rs2idx;
  assign o_prdt_taken = head.prdt_taken;

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        entry_d[wr_ptr_q] = '{ir: i_ir, pc: i_pc, pc_vld: i_pc_vld, rs1idx: i_rs1idx,
                              rs2idx: i_rs2idx, prdt_taken: i_prdt_taken};
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the storage array is
  // reset too, so the head payload reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entry_q  <= entry_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_push_full:  assert property (@(posedge clk) disable iff (!rst_n) !(push && o_full));
  a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst_n) !(pop && o_empty));
  a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_qpu_ifu2exu_ibuf.sv
// Self-checking bench for qpu_ifu2exu_ibuf (DEPTH=2): directed vector table, hand-written
// corner sequences and a random run checked against a queue-based reference model.
module tb_qpu_ifu2exu_ibuf;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_ready;
  logic [31:0] i_ir, i_pc;
  logic        i_pc_vld;
  logic [4:0]  i_rs1idx, i_rs2idx;
  logic        i_prdt_taken;
  logic        o_valid, o_ready;
  logic [31:0] o_ir, o_pc;
  logic        o_pc_vld;
  logic [4:0]  o_rs1idx, o_rs2idx;
  logic        o_prdt_taken;
  logic        flush;
  logic [1:0]  o_count;
  logic        o_full, o_empty;

  int n_pass  = 0;
  int n_total = 0;

  qpu_ifu2exu_ibuf dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_ir(i_ir), .i_pc(i_pc), .i_pc_vld(i_pc_vld),
    .i_rs1idx(i_rs1idx), .i_rs2idx(i_rs2idx), .i_prdt_taken(i_prdt_taken),
    .o_valid(o_valid), .o_ready(o_ready), .o_ir(o_ir), .o_pc(o_pc), .o_pc_vld(o_pc_vld),
    .o_rs1idx(o_rs1idx), .o_rs2idx(o_rs2idx), .o_prdt_taken(o_prdt_taken),
    .flush(flush), .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        pc_vld;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        prdt;
  } ent_t;

  ent_t mq[$];

  typedef struct {
    logic        iv;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        exp_ov;
    logic        exp_ir_rdy;
    logic [1:0]  exp_cnt;
    logic [31:0] exp_oir;
    logic [31:0] exp_opc;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One cycle against the reference model: compare at negedge, then update at posedge.
  task automatic step_model(input string tag, output bit dut_pop, output logic [31:0] dut_pc,
                            output bit exp_push);
    ent_t in_e;
    bit   exp_pop;
    int   sz;
    in_e = '{ir: i_ir, pc: i_pc, pc_vld: i_pc_vld, rs1: i_rs1idx, rs2: i_rs2idx,
             prdt: i_prdt_taken};
    @(negedge clk);
    sz       = mq.size();
    exp_push = i_valid && !flush && (sz < DEPTH);
    exp_pop  = o_ready && !flush && (sz > 0);
    check({tag, "_ovalid"}, 80'(o_valid), 80'(sz > 0 && !flush));
    check({tag, "_iready"}, 80'(i_ready), 80'(sz < DEPTH && !flush));
    check({tag, "_count"},  80'(o_count), 80'(sz));
    check({tag, "_full"},   80'(o_full),  80'(sz == DEPTH));
    check({tag, "_empty"},  80'(o_empty), 80'(sz == 0));
    if (sz > 0 && !flush)
      check({tag, "_payload"},
            80'({o_ir, o_pc, o_pc_vld, o_rs1idx, o_rs2idx, o_prdt_taken}), 80'(mq[0]));
    dut_pop = o_valid && o_ready;
    dut_pc  = o_pc;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (exp_pop)  void'(mq.pop_front());
      if (exp_push) mq.push_back(in_e);
    end
    #1;
  endtask

  bit          pp, pu;
  logic [31:0] ppc;

  initial begin
    rst_n = 1'b0; i_valid = 0; i_ir = 0; i_pc = 0; i_pc_vld = 0; i_rs1idx = 0; i_rs2idx = 0;
    i_prdt_taken = 0; o_ready = 0; flush = 0;

    #12;
    check("rst_ovalid", 80'(o_valid), 80'(0));
    check("rst_iready", 80'(i_ready), 80'(1));
    check("rst_empty",  80'(o_empty), 80'(1));
    check("rst_full",   80'(o_full),  80'(0));
    check("rst_count",  80'(o_count), 80'(0));
    check("rst_payload", 80'({o_ir, o_pc, o_pc_vld, o_rs1idx, o_rs2idx, o_prdt_taken}), 80'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // iv, ir, pc, ordy, fl | ov, i_ready, count, o_ir, o_pc
    vecs[0]  = '{1, 32'h11, 32'h100, 0, 0,  0, 1, 0, 32'h0,  32'h0};
    vecs[1]  = '{1, 32'h22, 32'h104, 0, 0,  1, 1, 1, 32'h11, 32'h100};
    vecs[2]  = '{1, 32'h33, 32'h108, 0, 0,  1, 0, 2, 32'h11, 32'h100};
    vecs[3]  = '{1, 32'h33, 32'h108, 1, 0,  1, 0, 2, 32'h11, 32'h100};
    vecs[4]  = '{1, 32'h33, 32'h108, 1, 0,  1, 1, 1, 32'h22, 32'h104};
    vecs[5]  = '{0, 32'h0,  32'h0,   1, 0,  1, 1, 1, 32'h33, 32'h108};
    vecs[6]  = '{0, 32'h0,  32'h0,   1, 0,  0, 1, 0, 32'h0,  32'h0};
    vecs[7]  = '{1, 32'h44, 32'h200, 0, 0,  0, 1, 0, 32'h0,  32'h0};
    vecs[8]  = '{1, 32'h55, 32'h204, 0, 0,  1, 1, 1, 32'h44, 32'h200};
    vecs[9]  = '{1, 32'h66, 32'h208, 0, 1,  0, 0, 2, 32'h0,  32'h0};
    vecs[10] = '{0, 32'h0,  32'h0,   1, 0,  0, 1, 0, 32'h0,  32'h0};
    vecs[11] = '{1, 32'h77, 32'h300, 1, 0,  0, 1, 0, 32'h0,  32'h0};
    vecs[12] = '{0, 32'h0,  32'h0,   1, 0,  1, 1, 1, 32'h77, 32'h300};

    for (int i = 0; i < 13; i++) begin
      i_valid = vecs[i].iv; i_ir = vecs[i].ir; i_pc = vecs[i].pc;
      o_ready = vecs[i].ordy; flush = vecs[i].fl;
      @(negedge clk);
      check($sformatf("vec%0d_ovalid", i), 80'(o_valid), 80'(vecs[i].exp_ov));
      check($sformatf("vec%0d_iready", i), 80'(i_ready), 80'(vecs[i].exp_ir_rdy));
      check($sformatf("vec%0d_count", i),  80'(o_count), 80'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_full", i),   80'(o_full),  80'(vecs[i].exp_cnt == 2'd2));
      check($sformatf("vec%0d_empty", i),  80'(o_empty), 80'(vecs[i].exp_cnt == 2'd0));
      if (vecs[i].exp_ov) begin
        check($sformatf("vec%0d_oir", i), 80'(o_ir), 80'(vecs[i].exp_oir));
        check($sformatf("vec%0d_opc", i), 80'(o_pc), 80'(vecs[i].exp_opc));
      end
      @(posedge clk); #1;
    end
    i_valid = 0; o_ready = 0; flush = 0;

    // Occupancy of one with a push and a pop every cycle for eight cycles.
    i_valid = 1; i_ir = 32'hA0; i_pc = 32'h400; i_rs1idx = 5'd1; i_rs2idx = 5'd2; i_pc_vld = 1;
    step_model("ss_fill", pp, ppc, pu);
    for (int k = 0; k < 8; k++) begin
      i_ir = 32'hA1 + 32'(k); i_pc = 32'h404 + 32'(4 * k); o_ready = 1;
      i_rs1idx = 5'(k); i_rs2idx = 5'(31 - k); i_prdt_taken = k[0];
      step_model("ss", pp, ppc, pu);
      check("ss_pop_pc", 80'(ppc), 80'(32'h400 + 32'(4 * k)));
    end
    i_valid = 0;
    step_model("ss_drain", pp, ppc, pu);

    // Random valid/ready: output PCs must form an unbroken +4 sequence.
    begin
      logic [31:0] next_pc, exp_pc;
      int popped_n, cyc;
      next_pc = 32'h1000; exp_pc = 32'h1000; popped_n = 0; cyc = 0;
      while (popped_n < 1000 && cyc < 20000) begin
        i_valid = ($urandom_range(0, 3) != 0); i_pc = next_pc; i_ir = $urandom;
        i_pc_vld = 1'($urandom); i_rs1idx = 5'($urandom); i_rs2idx = 5'($urandom);
        i_prdt_taken = 1'($urandom); o_ready = ($urandom_range(0, 2) != 0); flush = 0;
        step_model("rnd", pp, ppc, pu);
        if (pu) next_pc += 32'd4;
        if (pp) begin
          check("rnd_pc_seq", 80'(ppc), 80'(exp_pc));
          exp_pc += 32'd4;
          popped_n++;
        end
        cyc++;
      end
      check("rnd_done", 80'(popped_n), 80'(1000));
    end

    // Asynchronous reset with two entries held.
    i_valid = 0; o_ready = 0;
    while (mq.size() > 0) begin o_ready = 1; step_model("pre_rst_drain", pp, ppc, pu); end
    o_ready = 0; i_valid = 1; i_ir = 32'hBB;
    step_model("pre_rst", pp, ppc, pu);
    step_model("pre_rst", pp, ppc, pu);
    i_valid = 0;
    check("pre_rst_count", 80'(o_count), 80'(2));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ovalid", 80'(o_valid), 80'(0));
    check("async_rst_count",  80'(o_count), 80'(0));
    check("async_rst_iready", 80'(i_ready), 80'(1));
    mq.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
